// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-side pointer, full/almost-full and fill-level logic of an async FIFO.
// Ports: wr_clk/wr_rst (sync, active-high), wr_en, rd_gray_ptr (async Gray read pointer),
//        wr_addr (binary write pointer), wr_gray_ptr, full, almost_full, wr_count,
//        overflow (sticky, only when FIFO_OVERFLOW_EN is defined).
module fifo_wptr_full #(
  parameter int Addr_Width = 8,
  parameter int Almost_Full_Level = 2**Addr_Width - 2
) (
  input  logic                wr_clk,
  input  logic                wr_rst,
  input  logic                wr_en,
  input  logic [Addr_Width:0] rd_gray_ptr,
  output logic [Addr_Width:0] wr_addr,
  output logic [Addr_Width:0] wr_gray_ptr,
  output logic                full,
  output logic                almost_full,
  output logic [Addr_Width:0] wr_count
`ifdef FIFO_OVERFLOW_EN
  ,
  output logic                overflow
`endif
);
  localparam logic [Addr_Width:0] af_lvl = (Addr_Width+1)'(Almost_Full_Level);
  logic [Addr_Width:0] sync1, sync2, rd_bin_s, next_bin, next_gray, next_count;
  logic wr_inc, next_full;
  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i <= Addr_Width; i++) begin : g2b
    assign rd_bin_s[i] = ^sync2[Addr_Width:i];
  end
  assign wr_inc     = wr_en & ~full;
  assign next_bin   = wr_addr + (Addr_Width+1)'(wr_inc);
  assign next_gray  = next_bin ^ (next_bin >> 1);
  // Full when the write pointer is one lap ahead of the synchronized read pointer.
  assign next_full  = next_gray == {~sync2[Addr_Width:Addr_Width-1], sync2[Addr_Width-2:0]};
  assign next_count = next_bin - rd_bin_s;
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      sync1       <= '0;
      sync2       <= '0;
      wr_addr     <= '0;
      wr_gray_ptr <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_count    <= '0;
    end else begin
      sync1       <= rd_gray_ptr;
      sync2       <= sync1;
      wr_addr     <= next_bin;
      wr_gray_ptr <= next_gray;
      full        <= next_full;
      almost_full <= next_count >= af_lvl;
      wr_count    <= next_count;
    end
  end
`ifdef FIFO_OVERFLOW_EN
  always_ff @(posedge wr_clk) begin
    if (wr_rst) overflow <= 1'b0;
    else if (wr_en && full) overflow <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full: randomized check of fifo_wptr_full against a fill-level reference model.
module tb_fifo_wptr_full;
  localparam int AW = 2;
  localparam int AFL = 3;
  localparam int D = 4;
  localparam int M = 7;
  logic wr_clk = 1'b0;
  logic wr_rst = 1'b1;
  logic wr_en = 1'b0;
  logic [AW:0] rd_gray_ptr = '0;
  logic [AW:0] wr_addr, wr_gray_ptr, wr_count;
  logic full, almost_full;
`ifdef FIFO_OVERFLOW_EN
  logic overflow;
`endif
  int vecs = 0, errs = 0;
  int m_addr = 0, m_rd = 0, s1 = 0, s2 = 0, m_cnt = 0;
  bit m_full = 0, m_af = 0, m_ovf = 0;
  bit saw_wrap = 0;
  int max_cnt = 0;
  always #5 wr_clk = ~wr_clk;
  fifo_wptr_full #(.Addr_Width(AW), .Almost_Full_Level(AFL)) dut (
    .wr_clk(wr_clk),
    .wr_rst(wr_rst),
    .wr_en(wr_en),
    .rd_gray_ptr(rd_gray_ptr),
    .wr_addr(wr_addr),
    .wr_gray_ptr(wr_gray_ptr),
    .full(full),
    .almost_full(almost_full),
    .wr_count(wr_count)
`ifdef FIFO_OVERFLOW_EN
    ,
    .overflow(overflow)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic step(input bit rst, input bit we, input int rd);
    logic [AW:0] pa, pg;
    bit acc;
    pa = wr_addr;
    pg = wr_gray_ptr;
    wr_rst = rst;
    wr_en = we;
    rd_gray_ptr = (AW+1)'(rd ^ (rd >> 1));
    @(posedge wr_clk);
    acc = 0;
    if (rst) begin
      m_addr = 0; s1 = 0; s2 = 0; m_cnt = 0; m_full = 0; m_af = 0; m_ovf = 0;
    end else begin
      acc = we && !m_full;
      if (we && m_full) m_ovf = 1;
      if (acc && m_addr == M) saw_wrap = 1;
      m_addr = (m_addr + int'(acc)) & M;
      m_cnt = (m_addr - s2) & M;
      m_full = m_cnt == D;
      m_af = m_cnt >= AFL;
      s2 = s1;
      s1 = rd;
    end
    if (m_cnt > max_cnt) max_cnt = m_cnt;
    @(negedge wr_clk);
    chk("wr_addr", wr_addr, m_addr);
    chk("wr_gray_ptr", wr_gray_ptr, m_addr ^ (m_addr >> 1));
    chk("wr_count", wr_count, m_cnt);
    chk("full", full, m_full);
    chk("almost_full", almost_full, m_af);
`ifdef FIFO_OVERFLOW_EN
    chk("overflow", overflow, m_ovf);
`endif
    if (!rst) begin
      chk("gray_hamming", $countones(wr_gray_ptr ^ pg), acc);
      if (m_full && !acc && pa == wr_addr) chk("addr_hold_full", wr_addr, pa);
    end
  endtask
  initial begin
    step(1, 1, 0);
    step(1, 1, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_gray", wr_gray_ptr, 0);
    chk("rst_full", full, 0);
    chk("rst_count", wr_count, 0);
    step(0, 1, 0); chk("fill_g1", wr_gray_ptr, 3'b001); chk("fill_af1", almost_full, 0);
    step(0, 1, 0); chk("fill_g2", wr_gray_ptr, 3'b011); chk("fill_af2", almost_full, 0);
    step(0, 1, 0); chk("fill_g3", wr_gray_ptr, 3'b010); chk("fill_af3", almost_full, 1);
    chk("fill_full3", full, 0);
    step(0, 1, 0); chk("fill_g4", wr_gray_ptr, 3'b110); chk("fill_full4", full, 1);
    chk("fill_addr4", wr_addr, 4);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0);
      chk("ovr_addr", wr_addr, 4);
      chk("ovr_count", wr_count, 4);
    end
`ifdef FIFO_OVERFLOW_EN
    step(0, 0, 0);
    chk("ovf_sticky", overflow, 1);
`endif
    m_rd = 1;
    step(0, 0, m_rd); chk("drain_e1", full, 1);
    step(0, 0, m_rd); chk("drain_e2", full, 1); chk("drain_c2", wr_count, 4);
    step(0, 0, m_rd); chk("drain_e3", full, 0); chk("drain_c3", wr_count, 3);
    step(1, 0, 0);
    m_rd = 0;
    step(0, 1, m_rd); chk("first_after_rst", wr_addr, 1);
    step(0, 1, m_rd);
    step(1, 1, 0);
    step(0, 1, m_rd); chk("refill_after_rst", wr_addr, 1);
    step(1, 0, 0);
    saw_wrap = 0;
    max_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 1, m_rd);
      chk("wrap_nofull_w", full, 0);
      m_rd = (m_addr - 1) & M;
      step(0, 0, m_rd);
      chk("wrap_nofull_r", full, 0);
    end
    chk("wrap_seen", saw_wrap, 1);
    chk("wrap_max_le4", max_cnt <= D, 1);
    for (int i = 0; i < 600; i++) begin
      bit rst, we;
      rst = $urandom_range(0, 99) < 2;
      we = ($urandom_range(0, 99) < 60);
      if (rst) m_rd = 0;
      else if (((m_addr - m_rd) & M) > 0 && $urandom_range(0, 99) < 45) m_rd = (m_rd + 1) & M;
      step(rst, we, m_rd);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/fifo_wptr_full.md
FIFO_WPTR_FULL -- requirements
Module: fifo_wptr_full

Interface
REQ-001 The block SHALL have parameter Addr_Width, default 8, the memory address width; depth is 2**Addr_Width, legal range 2..16.
REQ-002 The block SHALL have parameter Almost_Full_Level, default 2**Addr_Width-2, the fill level at or above which almost_full asserts; legal range 1..2**Addr_Width.
REQ-003 wr_clk  input  1  write-domain clock; the only clock in the block; all flops on its rising edge.
REQ-004 wr_rst  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  write request from the producer.
REQ-006 rd_gray_ptr  input  Addr_Width+1  Gray-coded read pointer, asynchronous to wr_clk and driven by the read domain.
REQ-007 wr_addr  output  Addr_Width+1  registered binary write pointer; low Addr_Width bits index the FIFO memory; MSB is the wrap bit.
REQ-008 wr_gray_ptr  output  Addr_Width+1  registered Gray-coded write pointer, exported to the read domain.
REQ-009 full  output  1  registered full flag, fed to the memory write gate and to the producer.
REQ-010 almost_full  output  1  registered flag: fill level >= Almost_Full_Level.
REQ-011 wr_count  output  Addr_Width+1  registered write-side fill level, 0..2**Addr_Width.
REQ-012 overflow  output  1  sticky overflow flag; present only when FIFO_OVERFLOW_EN is defined.

Function
REQ-013 rd_gray_ptr SHALL pass through a two-flop synchronizer clocked by wr_clk (sync1, then sync2), with no logic between the stages.
REQ-014 sync2 SHALL be converted combinationally from Gray to binary (rd_bin_s): MSB copied; each lower bit is the XOR of the next-higher binary bit and its own Gray bit.
REQ-015 wr_inc SHALL equal wr_en AND NOT full; a write while full SHALL be dropped, and no pointer or flag SHALL change because of it.
REQ-016 Next binary pointer = wr_addr + wr_inc, modulo 2**(Addr_Width+1); next Gray = next_bin XOR (next_bin >> 1); both registered each cycle.
REQ-017 Next full SHALL be true iff next Gray equals sync2 with its two MSBs inverted and its remaining bits equal.
REQ-018 Next wr_count = (next_bin - rd_bin_s) modulo 2**(Addr_Width+1); next almost_full = (next wr_count >= Almost_Full_Level); both registered.
REQ-019 A write on cycle N SHALL be reflected in wr_addr, wr_gray_ptr, wr_count, full and almost_full at edge N+1 (one-cycle latency).
REQ-020 A read-pointer change SHALL be reflected in full, almost_full and wr_count within three wr_clk edges; full is pessimistic (late deassertion) and SHALL never deassert early.
REQ-021 Pointer wrap at 2**(Addr_Width+1)-1 -> 0 SHALL be seamless; wr_count SHALL stay correct across the wrap.
REQ-022 wr_gray_ptr SHALL change by exactly one bit per write, and SHALL not change on cycles with no write.
REQ-023 An empty-to-full fill SHALL take exactly 2**Addr_Width accepted writes; full asserts on the edge of the last one.

Reset
REQ-024 On a wr_clk edge with wr_rst=1, the following SHALL clear to 0: wr_addr, wr_gray_ptr, sync1, sync2, full, almost_full, wr_count, and overflow.
REQ-025 Reset SHALL take priority over wr_en; reset mid-fill SHALL discard the fill state, and the first accepted write after reset SHALL produce wr_addr=1.
REQ-026 Reset release SHALL need no minimum pulse beyond one wr_clk edge.

Configuration
REQ-027 Macro FIFO_OVERFLOW_EN defined: overflow SHALL set on the edge after any cycle with wr_en=1 and full=1, and SHALL hold until wr_rst.
REQ-028 Macro FIFO_OVERFLOW_EN undefined: the overflow port and its flop SHALL not exist; all other behaviour SHALL be identical.

Verification (Addr_Width=2, Almost_Full_Level=3)
REQ-029 Reset: assert wr_rst for 2 edges with wr_en=1 -> wr_addr=0, wr_gray_ptr=0, full=0, wr_count=0.
REQ-030 Fill: rd_gray_ptr=0, then 4 consecutive writes -> wr_addr 1,2,3,4; wr_gray_ptr 001,011,010,110; almost_full at count 3; full=1 after the 4th write.
REQ-031 Write while full: with full=1, 3 extra writes -> wr_addr stays 4, wr_count stays 4; overflow=1 if FIFO_OVERFLOW_EN, and it stays 1 until reset.
REQ-032 Drain visibility: with the block full, set rd_gray_ptr=001 -> full=0 and wr_count=3 on the third edge, and not earlier.
REQ-033 Wrap: 12 writes interleaved with reads that keep rd_gray_ptr one behind -> wr_addr wraps 7->0, wr_count never exceeds 4, full never falsely set.
REQ-034 Every simulation: Gray Hamming-distance assertion on wr_gray_ptr, plus an assertion that wr_addr never advances while full=1.
